// File: rtl/crypto_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crypto_pkg
//  Description : Shared definitions for the instruction front end and the
//                control unit: default widths, opcode encodings and the
//                fetch FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package crypto_pkg;

    // Default widths
    localparam int c_addr_w_def  = 8;
    localparam int c_instr_w_def = 16;

    // Opcode encodings (upper 4 bits of the instruction word)
    localparam logic [3:0] c_op_nop  = 4'h0;
    localparam logic [3:0] c_op_load = 4'h1;
    localparam logic [3:0] c_op_add  = 4'h2;
    localparam logic [3:0] c_op_sub  = 4'h3;
    localparam logic [3:0] c_op_and  = 4'h4;
    localparam logic [3:0] c_op_or   = 4'h5;
    localparam logic [3:0] c_op_jmp  = 4'h8;
    localparam logic [3:0] c_op_beq  = 4'h9;
    localparam logic [3:0] c_op_halt = 4'hF;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STALL  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : DEPTH x WIDTH synchronous FIFO used as the prefetch buffer.
//                Simultaneous push and pop keep the occupancy unchanged.
//                flush empties the buffer in one cycle.
//  Ports       : clk, reset (async, active-low), flush, push, wr_data, pop,
//                rd_data (head entry), full, empty, count
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // A push into a full buffer is only legal when a pop frees a slot
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = (r_count == c_cnt_w'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction fetch front end. Owns the PC, fetches words over
//                a req/ack memory handshake into a prefetch FIFO and presents
//                the head as opcode/operand with valid/ready. Stops after a
//                HALT opcode; accepts PC redirects from any state.
//  Ports       : clk, reset (async, active-low)
//                imem_req/imem_addr/imem_ack/imem_rdata : instruction memory
//                instr_valid/opcode/operand/instr_pc/instr_ready : consumer
//                redirect_valid/redirect_addr : jump/branch target
//                halted, state : status and debug
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import crypto_pkg::*;
#(
    parameter int         ADDR_W  = c_addr_w_def,
    parameter int         INSTR_W = c_instr_w_def,
    parameter int         DEPTH   = 2,
    parameter logic [3:0] HALT_OP = c_op_halt
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                instr_valid,
    output logic [3:0]          opcode,
    output logic [INSTR_W-5:0]  operand,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                instr_ready,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_addr,
    output logic                halted,
    output logic [1:0]          state
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam int c_ent_w = INSTR_W + ADDR_W;

    fetch_state_t        r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_req;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_halted;
    logic                r_discard;   // in-flight response belongs to a flushed path

    logic                w_ack;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [c_cnt_w-1:0]  w_count;
    logic [c_cnt_w-1:0]  w_cnt_next;
    logic [c_ent_w-1:0]  w_rd_data;
    logic [INSTR_W-1:0]  w_head_word;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic                w_is_halt;

    // Acks with no request outstanding are ignored
    assign w_ack     = imem_ack && r_req;
    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_is_halt = (imem_rdata[INSTR_W-1 -: 4] == HALT_OP);

    // Redirect flushes the buffer, so it overrides any same-cycle push/pop
    assign w_push = w_ack && !r_discard && !redirect_valid && (r_state == ST_FETCH);
    assign w_pop  = instr_ready && !w_empty && !redirect_valid;

    always_comb begin
        w_cnt_next = w_count;
        if (w_push && !w_pop) begin
            w_cnt_next = w_count + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            w_cnt_next = w_count - c_cnt_w'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ent_w)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (redirect_valid),
        .push    (w_push),
        .wr_data ({imem_rdata, r_pc}),
        .pop     (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_req     <= 1'b0;
            r_addr    <= '0;
            r_halted  <= 1'b0;
            r_discard <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= redirect_addr;
            r_halted <= 1'b0;
            r_state  <= ST_FETCH;
            if (r_req && !imem_ack) begin
                // Memory still owes a response: keep the bus stable until it
                // arrives, then throw it away.
                r_discard <= 1'b1;
            end else begin
                r_discard <= 1'b0;
                r_req     <= 1'b1;
                r_addr    <= redirect_addr;
            end
        end else if (r_discard) begin
            if (w_ack) begin
                r_discard <= 1'b0;
                r_req     <= 1'b1;
                r_addr    <= r_pc;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                end
                ST_FETCH: begin
                    if (w_ack) begin
                        r_pc <= w_pc_inc;
                        if (w_is_halt) begin
                            r_state  <= ST_HALTED;
                            r_req    <= 1'b0;
                            r_halted <= 1'b1;
                        end else if (w_cnt_next == c_cnt_w'(DEPTH)) begin
                            // No room for another response: stop requesting
                            r_state <= ST_STALL;
                            r_req   <= 1'b0;
                        end else begin
                            r_addr <= w_pc_inc;
                        end
                    end
                end
                ST_STALL: begin
                    if (!w_full || w_pop) begin
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                    end
                end
                ST_HALTED: begin
                    r_req <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign halted      = r_halted;
    assign state       = r_state;

    assign {w_head_word, instr_pc} = w_rd_data;
    assign instr_valid = !w_empty;
    assign opcode      = w_head_word[INSTR_W-1 -: 4];
    assign operand     = w_head_word[INSTR_W-5:0];

endmodule
`default_nettype wire
